// File: rtl/spi_transaction_fsm_pkg.sv
// Shared state encoding, parameter defaults and output decode for the SPI
// transaction controller.
package spi_transaction_fsm_pkg;

   localparam int WORD_WIDTH_DEFAULT  = 8;
   localparam int CNT_WIDTH_DEFAULT   = 4;
   localparam int SYNC_STAGES_DEFAULT = 2;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      GET_ADDR    = 3'd1,
      DECODE      = 3'd2,
      READ_LOAD   = 3'd3,
      READ_SHIFT  = 3'd4,
      WRITE_SHIFT = 3'd5,
      WRITE_MEM   = 3'd6,
      DONE        = 3'd7
   } state_t;

   typedef struct packed {
      logic addr_latch;
      logic sr_load;
      logic dm_write;
      logic miso_en;
      logic busy;
   } ctrl_t;

   // Control outputs are pure functions of the state the FSM is in.
   function automatic ctrl_t decode_state(input state_t s);
      ctrl_t c;
      c            = '0;
      c.addr_latch = (s == DECODE);
      c.sr_load    = (s == READ_LOAD);
      c.dm_write   = (s == WRITE_MEM);
      c.miso_en    = (s == READ_SHIFT);
      c.busy       = (s != IDLE);
      return c;
   endfunction

endpackage

// File: rtl/spi_transaction_fsm_input_conditioner.sv
// Synchronises one asynchronous pin and produces registered single-cycle
// rising/falling edge pulses of the synchronised level.
module spi_transaction_fsm_input_conditioner
   import spi_transaction_fsm_pkg::*;
#(
   parameter int   syncStages = SYNC_STAGES_DEFAULT,
   parameter logic RESET_VAL  = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic pin_i,
   output logic sync_o,
   output logic pos_edge_o,
   output logic neg_edge_o
);

   logic sync_q [syncStages];
   logic hist_q;
   logic pos_q;
   logic neg_q;

   genvar gi;
   generate
      for (gi = 0; gi < syncStages; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
               if (reset) sync_q[gi] <= RESET_VAL;
               else       sync_q[gi] <= pin_i;
            end
         end else begin : g_chain
            always_ff @(posedge clk) begin
               if (reset) sync_q[gi] <= RESET_VAL;
               else       sync_q[gi] <= sync_q[gi-1];
            end
         end
      end
   endgenerate

   assign sync_o = sync_q[syncStages-1];

   // hist_q holds the previous synchronised level so edges are seen once.
   always_ff @(posedge clk) begin
      if (reset) begin
         hist_q <= RESET_VAL;
         pos_q  <= 1'b0;
         neg_q  <= 1'b0;
      end else begin
         hist_q <= sync_o;
         pos_q  <= sync_o & ~hist_q;
         neg_q  <= ~sync_o & hist_q;
      end
   end

   assign pos_edge_o = pos_q;
   assign neg_edge_o = neg_q;

endmodule

// File: rtl/spi_transaction_fsm.sv
// SPI transaction sequencer: conditions SCLK/CS and walks one address/RW
// byte followed by a read or write data byte, driving the datapath strobes.
module spi_transaction_fsm
   import spi_transaction_fsm_pkg::*;
#(
   parameter int wordWidth  = WORD_WIDTH_DEFAULT,
   parameter int cntWidth   = CNT_WIDTH_DEFAULT,
   parameter int syncStages = SYNC_STAGES_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic sclkIn,
   input  logic csIn,
   input  logic rwBit,
   output logic sclkPosEdge,
   output logic sclkNegEdge,
   output logic addrLatchEn,
   output logic srParallelLoad,
   output logic dmWriteEnable,
   output logic misoBufEnable,
   output logic busy
);

   localparam logic [cntWidth-1:0] WORD_CNT = cntWidth'(wordWidth);

   logic sclk_pos;
   logic sclk_neg;
   logic sclk_level_unused;
   logic cs_sync;
   logic cs_pos_unused;
   logic cs_neg_unused;
   logic cs_active;

   spi_transaction_fsm_input_conditioner #(
      .syncStages (syncStages),
      .RESET_VAL  (1'b0)
   ) u_sclk_cond (
      .clk        (clk),
      .reset      (reset),
      .pin_i      (sclkIn),
      .sync_o     (sclk_level_unused),
      .pos_edge_o (sclk_pos),
      .neg_edge_o (sclk_neg)
   );

   // CS idles high, so its flops reset to the deasserted level.
   spi_transaction_fsm_input_conditioner #(
      .syncStages (syncStages),
      .RESET_VAL  (1'b1)
   ) u_cs_cond (
      .clk        (clk),
      .reset      (reset),
      .pin_i      (csIn),
      .sync_o     (cs_sync),
      .pos_edge_o (cs_pos_unused),
      .neg_edge_o (cs_neg_unused)
   );

   assign cs_active = ~cs_sync;

   state_t              state_q, state_d;
   logic [cntWidth-1:0] cnt_q, cnt_d;
   logic [cntWidth-1:0] cnt_inc;
   ctrl_t               ctrl_q, ctrl_d;

   assign cnt_inc = (cnt_q >= WORD_CNT) ? WORD_CNT : cnt_q + cntWidth'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (cs_active) state_d = GET_ADDR;
         end
         GET_ADDR: begin
            if (sclk_pos) begin
               cnt_d = cnt_inc;
               if (cnt_inc == WORD_CNT) state_d = DECODE;
            end
         end
         DECODE: begin
            cnt_d   = '0;
            state_d = rwBit ? READ_LOAD : WRITE_SHIFT;
         end
         READ_LOAD: begin
            state_d = READ_SHIFT;
         end
         READ_SHIFT: begin
            if (sclk_neg) begin
               cnt_d = cnt_inc;
               if (cnt_inc == WORD_CNT) state_d = DONE;
            end
         end
         WRITE_SHIFT: begin
            if (sclk_pos) begin
               cnt_d = cnt_inc;
               if (cnt_inc == WORD_CNT) state_d = WRITE_MEM;
            end
         end
         WRITE_MEM: begin
            state_d = cs_active ? DONE : IDLE;
         end
         DONE: begin
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // A CS release overrides any counting edge in the same cycle; only the
      // memory commit is allowed to finish.
      if (!cs_active && state_q != WRITE_MEM) begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end

   assign ctrl_d = decode_state(state_d);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign sclkPosEdge    = sclk_pos;
   assign sclkNegEdge    = sclk_neg;
   assign addrLatchEn    = ctrl_q.addr_latch;
   assign srParallelLoad = ctrl_q.sr_load;
   assign dmWriteEnable  = ctrl_q.dm_write;
   assign misoBufEnable  = ctrl_q.miso_en;
   assign busy           = ctrl_q.busy;

endmodule

// File: tb/tb_spi_transaction_fsm.sv
// Bench for spi_transaction_fsm: a directed vector table, hand-written
// transaction sequences and randomized traffic against a reference model.
`timescale 1ns/1ps
module tb_spi_transaction_fsm;

   localparam int MAXC = 65536;
   localparam int WORD = 8;

   logic clk = 1'b0;
   logic reset, sclkIn, csIn, rwBit;
   logic sclkPosEdge, sclkNegEdge, addrLatchEn, srParallelLoad;
   logic dmWriteEnable, misoBufEnable, busy;

   spi_transaction_fsm dut (
      .clk            (clk),
      .reset          (reset),
      .sclkIn         (sclkIn),
      .csIn           (csIn),
      .rwBit          (rwBit),
      .sclkPosEdge    (sclkPosEdge),
      .sclkNegEdge    (sclkNegEdge),
      .addrLatchEn    (addrLatchEn),
      .srParallelLoad (srParallelLoad),
      .dmWriteEnable  (dmWriteEnable),
      .misoBufEnable  (misoBufEnable),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_mis = 0;
   bit check_en = 1'b0;

   logic [6:0] dut_vec;
   assign dut_vec = {sclkPosEdge, sclkNegEdge, addrLatchEn, srParallelLoad,
                     dmWriteEnable, misoBufEnable, busy};

   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_mis++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Pin samples per clock edge; the conditioned view is the pin one edge
   // earlier, forced to the idle level around a reset.
   bit sclk_s [MAXC];
   bit cs_s   [MAXC];
   bit rst_s  [MAXC];

   function automatic bit seen(input bit is_cs, input int j);
      if (j < 1) return is_cs;
      if (rst_s[j] || rst_s[j-1]) return is_cs;
      return is_cs ? cs_s[j-1] : sclk_s[j-1];
   endfunction

   function automatic bit hist(input bit is_cs, input int j);
      if (j < 0 || rst_s[j]) return is_cs;
      return seen(is_cs, j-1);
   endfunction

   function automatic bit pulse(input bit rising, input int j);
      bit now_v, old_v;
      if (j < 0 || rst_s[j]) return 1'b0;
      now_v = seen(1'b0, j-1);
      old_v = hist(1'b0, j-1);
      return rising ? (now_v & ~old_v) : (~now_v & old_v);
   endfunction

   typedef enum int {PH_IDLE, PH_ADDR, PH_DECODE, PH_RLOAD, PH_RDATA,
                     PH_WDATA, PH_COMMIT, PH_WAIT_CS} phase_t;
   phase_t ph   = PH_IDLE;
   int     bits = 0;
   int     cyc  = 0;
   logic [6:0] exp_vec;

   task automatic model_step(input int m, input bit rw);
      bit cs_act, pe, ne;
      if (rst_s[m]) begin
         ph = PH_IDLE; bits = 0; return;
      end
      cs_act = !seen(1'b1, m-1);
      pe     = pulse(1'b1, m-1);
      ne     = pulse(1'b0, m-1);
      if (!cs_act && ph != PH_COMMIT) begin
         ph = PH_IDLE; bits = 0; return;
      end
      case (ph)
         PH_IDLE:    begin bits = 0; ph = PH_ADDR; end
         PH_ADDR:    if (pe) begin bits++; if (bits == WORD) ph = PH_DECODE; end
         PH_DECODE:  begin bits = 0; ph = rw ? PH_RLOAD : PH_WDATA; end
         PH_RLOAD:   ph = PH_RDATA;
         PH_RDATA:   if (ne) begin bits++; if (bits == WORD) ph = PH_WAIT_CS; end
         PH_WDATA:   if (pe) begin bits++; if (bits == WORD) ph = PH_COMMIT; end
         PH_COMMIT:  ph = cs_act ? PH_WAIT_CS : PH_IDLE;
         default:    ;
      endcase
   endtask

   always begin
      @(posedge clk);
      if (cyc >= MAXC) begin
         $display("FAIL cycle_budget: got %0d cycles, required < %0d", cyc, MAXC);
         $fatal(1, "cycle budget exhausted");
      end
      sclk_s[cyc] = sclkIn;
      cs_s[cyc]   = csIn;
      rst_s[cyc]  = reset;
      model_step(cyc, rwBit);
      exp_vec = {pulse(1'b1, cyc), pulse(1'b0, cyc), ph == PH_DECODE, ph == PH_RLOAD,
                 ph == PH_COMMIT, ph == PH_RDATA, ph != PH_IDLE};
      cyc++;
      #1;
      if (check_en) compare("model", dut_vec, exp_vec);
   end

   // ---------------- event counters (sampled mid-cycle) ----------------
   localparam int K_ADDR = 0, K_SRL = 1, K_DM = 2, K_MISO = 3, K_BUSYLO = 4, K_ORDER = 5;
   int   cnt [6];
   int   base [6];
   logic prev_addr = 1'b0;

   initial for (int i = 0; i < 6; i++) cnt[i] = 0;

   always @(negedge clk) begin
      if (addrLatchEn)    cnt[K_ADDR]++;
      if (srParallelLoad) cnt[K_SRL]++;
      if (dmWriteEnable)  cnt[K_DM]++;
      if (misoBufEnable)  cnt[K_MISO]++;
      if (!busy)          cnt[K_BUSYLO]++;
      if (srParallelLoad && !prev_addr) cnt[K_ORDER]++;
      prev_addr = addrLatchEn;
   end

   task automatic snap();
      for (int i = 0; i < 6; i++) base[i] = cnt[i];
   endtask

   function automatic int delta(input int k);
      return cnt[k] - base[k];
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic sclk_periods(input int n);
      for (int i = 0; i < n; i++) begin
         sclkIn = 1'b1; ticks(10);
         sclkIn = 1'b0; ticks(10);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit         rst;
      bit         sclk;
      bit         cs;
      bit         rw;
      logic [6:0] exp;
   } vec_t;

   localparam logic [6:0] E0   = 7'b0000000;
   localparam logic [6:0] EPOS = 7'b1000000;
   localparam logic [6:0] ENEG = 7'b0100000;
   localparam logic [6:0] EBSY = 7'b0000001;

   localparam int NTBL = 29;
   vec_t tbl [NTBL];

   function automatic vec_t mk(input bit r, input bit s, input bit c, input logic [6:0] e);
      vec_t v;
      v.rst = r; v.sclk = s; v.cs = c; v.rw = 1'b0; v.exp = e;
      return v;
   endfunction

   int np, abort_at, rd_miso;
   bit do_abort, do_rst;

   initial begin
      reset = 1'b1; sclkIn = 1'b1; csIn = 1'b1; rwBit = 1'b0;

      // reset with SCLK toggling, then park at idle levels
      tbl[0]  = mk(1, 1, 1, E0);   tbl[1]  = mk(1, 0, 1, E0);
      tbl[2]  = mk(1, 1, 1, E0);   tbl[3]  = mk(1, 0, 1, E0);
      tbl[4]  = mk(1, 0, 1, E0);   tbl[5]  = mk(1, 0, 1, E0);
      tbl[6]  = mk(0, 0, 1, E0);
      // SCLK rises before edge 7: pulse visible after edge 9 only
      tbl[7]  = mk(0, 1, 1, E0);   tbl[8]  = mk(0, 1, 1, E0);
      tbl[9]  = mk(0, 1, 1, EPOS); tbl[10] = mk(0, 1, 1, E0);
      // SCLK falls before edge 11: pulse visible after edge 13 only
      tbl[11] = mk(0, 0, 1, E0);   tbl[12] = mk(0, 0, 1, E0);
      tbl[13] = mk(0, 0, 1, ENEG); tbl[14] = mk(0, 0, 1, E0);
      // CS low: busy three edges later; CS high: idle three edges later
      tbl[15] = mk(0, 0, 0, E0);   tbl[16] = mk(0, 0, 0, E0);
      tbl[17] = mk(0, 0, 0, EBSY); tbl[18] = mk(0, 0, 0, EBSY);
      tbl[19] = mk(0, 0, 1, EBSY); tbl[20] = mk(0, 0, 1, EBSY);
      tbl[21] = mk(0, 0, 1, E0);   tbl[22] = mk(0, 0, 1, E0);
      // reset while CS is held low drops busy at once
      tbl[23] = mk(0, 0, 0, E0);   tbl[24] = mk(0, 0, 0, E0);
      tbl[25] = mk(0, 0, 0, EBSY); tbl[26] = mk(1, 0, 0, E0);
      tbl[27] = mk(0, 0, 1, E0);   tbl[28] = mk(0, 0, 1, E0);

      for (int i = 0; i < NTBL; i++) begin
         reset  = tbl[i].rst;
         sclkIn = tbl[i].sclk;
         csIn   = tbl[i].cs;
         rwBit  = tbl[i].rw;
         tick();
         compare($sformatf("table[%0d]", i), dut_vec, tbl[i].exp);
      end

      check_en = 1'b1;

      // write transaction
      snap();
      csIn = 1'b0; rwBit = 1'b0; ticks(5);
      sclk_periods(8); sclk_periods(8); ticks(4);
      compare("wr_addr_latch", delta(K_ADDR), 1);
      compare("wr_dm_write", delta(K_DM), 1);
      compare("wr_sr_load", delta(K_SRL), 0);
      compare("wr_miso", delta(K_MISO), 0);
      compare("wr_busy_in_done", busy, 1);
      csIn = 1'b1; ticks(4);
      compare("wr_busy_after_cs", busy, 0);

      // read transaction
      snap();
      csIn = 1'b0; rwBit = 1'b1; ticks(5);
      sclk_periods(8); sclk_periods(8); ticks(4);
      rd_miso = delta(K_MISO);
      compare("rd_addr_latch", delta(K_ADDR), 1);
      compare("rd_sr_load", delta(K_SRL), 1);
      compare("rd_load_after_latch", delta(K_ORDER), 0);
      compare("rd_dm_write", delta(K_DM), 0);
      compare("rd_miso_seen", rd_miso > 0, 1);
      compare("rd_miso_off_in_done", misoBufEnable, 0);
      csIn = 1'b1; ticks(4);
      compare("rd_busy_after_cs", busy, 0);

      // abort after the fifth data posedge of a write
      snap();
      csIn = 1'b0; rwBit = 1'b0; ticks(5);
      sclk_periods(8); sclk_periods(4);
      sclkIn = 1'b1; ticks(5);
      csIn = 1'b1; ticks(3);
      compare("abort_idle", busy, 0);
      sclkIn = 1'b0; ticks(10);
      compare("abort_no_write", delta(K_DM), 0);

      // CS release landing with the final data posedge: abort wins
      snap();
      csIn = 1'b0; ticks(5);
      sclk_periods(8); sclk_periods(7);
      sclkIn = 1'b1; tick();
      csIn = 1'b1; ticks(8);
      compare("abort_final_edge_dm", delta(K_DM), 0);
      compare("abort_final_edge_busy", busy, 0);
      sclkIn = 1'b0; ticks(5);

      // full write after aborts, then extra SCLK in DONE with CS still low
      snap();
      csIn = 1'b0; ticks(5);
      sclk_periods(16); ticks(4);
      compare("rewrite_dm_write", delta(K_DM), 1);
      snap();
      sclk_periods(8);
      compare("done_extra_pulses", delta(K_ADDR) + delta(K_SRL) + delta(K_DM), 0);
      compare("done_extra_busy_low", delta(K_BUSYLO), 0);
      csIn = 1'b1; ticks(4);
      compare("done_release_busy", busy, 0);

      // randomized traffic, checked cycle by cycle against the model
      for (int t = 0; t < 40; t++) begin
         np       = $urandom_range(0, 20);
         do_abort = ($urandom_range(0, 3) == 0);
         do_rst   = ($urandom_range(0, 7) == 0);
         abort_at = $urandom_range(0, 20);
         csIn = 1'b0; ticks($urandom_range(1, 6));
         for (int p = 0; p < np; p++) begin
            rwBit  = 1'($urandom_range(0, 1));
            sclkIn = 1'b1; ticks($urandom_range(1, 12));
            sclkIn = 1'b0; ticks($urandom_range(1, 12));
            if (do_abort && p == abort_at) csIn = 1'b1;
            if (do_rst && p == abort_at) begin
               reset = 1'b1; ticks($urandom_range(1, 3)); reset = 1'b0;
            end
         end
         csIn = 1'b1; ticks($urandom_range(3, 8));
      end

      ticks(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
